// File: rtl/wb_arbiter_2m.sv
// ============================================================================
// Module   : wb_arbiter_2m
// Purpose  : Two-master to one-slave Wishbone classic arbiter with round-robin
//            grant and a per-cycle watchdog.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_arbiter_2m #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [29:0] m0_adr_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [29:0] m1_adr_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [29:0] s_adr_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,

    output logic [1:0]  gnt_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [1:0]  gnt_q,   gnt_d;
    logic        last_q,  last_d;
    logic [7:0]  cnt_q,   cnt_d;

    logic        w_busy;
    logic        w_sel_m1;
    logic        w_g_stb;
    logic        w_g_we;
    logic [29:0] w_g_adr;
    logic [3:0]  w_g_sel;
    logic [31:0] w_g_dat;
    logic        w_abort;
    logic        w_ack;
    logic        w_tmo;
    logic        w_pick_m1;

    // ------------------------------------------------------------------
    // Request mux from the granted master
    // ------------------------------------------------------------------
    assign w_busy   = (state_q == ST_BUSY);
    assign w_sel_m1 = gnt_q[1];

    always_comb begin
        w_g_stb = m0_stb_i;
        w_g_we  = m0_we_i;
        w_g_adr = m0_adr_i;
        w_g_sel = m0_sel_i;
        w_g_dat = m0_dat_i;
        if (w_sel_m1) begin
            w_g_stb = m1_stb_i;
            w_g_we  = m1_we_i;
            w_g_adr = m1_adr_i;
            w_g_sel = m1_sel_i;
            w_g_dat = m1_dat_i;
        end
    end

    // Termination causes; abort dominates, then ack beats the watchdog.
    assign w_abort = w_busy & ~w_g_stb;
    assign w_ack   = w_busy &  w_g_stb &  s_ack_i;
    assign w_tmo   = w_busy &  w_g_stb & ~s_ack_i & (cnt_q == c_tmo_last);

    // m0 wins unless m1 is the only requester or m0 held the last grant.
    assign w_pick_m1 = m1_stb_i & (~m0_stb_i | ~last_q);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (m0_stb_i | m1_stb_i) begin
                    state_d = ST_BUSY;
                    gnt_d   = w_pick_m1 ? 2'b10 : 2'b01;
                end
            end
            ST_BUSY: begin
                if (w_abort | w_ack | w_tmo) begin
                    state_d = ST_IDLE;
                    gnt_d   = 2'b00;
                    last_d  = w_sel_m1;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Output routing; everything is gated by BUSY so reset clears it at once
    // ------------------------------------------------------------------
    always_comb begin
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = 30'd0;
        s_sel_o  = 4'd0;
        s_dat_o  = 32'd0;
        m0_dat_o = 32'd0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = 32'd0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        if (w_busy) begin
            s_stb_o = w_g_stb & ~w_tmo;
            s_we_o  = w_g_we;
            s_adr_o = w_g_adr;
            s_sel_o = w_g_sel;
            s_dat_o = w_g_dat;
            if (w_sel_m1) begin
                m1_dat_o = w_tmo ? ERR_DATA : s_dat_i;
                m1_ack_o = w_ack;
                m1_err_o = w_tmo;
            end else begin
                m0_dat_o = w_tmo ? ERR_DATA : s_dat_i;
                m0_ack_o = w_ack;
                m0_err_o = w_tmo;
            end
        end
    end

    assign gnt_o = gnt_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter_2m.sv
// ============================================================================
// Module   : tb_wb_arbiter_2m
// Purpose  : Scoreboard bench for wb_arbiter_2m with a transaction-level
//            round-robin model and a reactive slave.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_arbiter_2m;

    localparam int          TMO  = 4;
    localparam logic [31:0] EDAT = 32'hDEADBEEF;
    localparam int          NEVER = 255;

    typedef struct {
        logic        we;
        logic [29:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          lat_l;     // slave acks on this stb cycle index (0-based)
        logic [31:0] rdata;
        int          abort_k;   // master drops stb in this BUSY cycle; 0 = never
        int          lat_exp;   // expected request-to-response cycles; -1 = unchecked
    } txn_t;

    typedef struct {
        int          mid;
        bit          is_err;
        logic [31:0] dat;
        int          lat;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        m0_stb_i, m0_we_i, m1_stb_i, m1_we_i;
    logic [29:0] m0_adr_i, m1_adr_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic [31:0] m0_dat_i, m1_dat_i;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic        s_stb_o, s_we_o;
    logic [29:0] s_adr_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_dat_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i;
    logic [1:0]  gnt_o;

    wb_arbiter_2m #(.TIMEOUT(TMO), .ERR_DATA(EDAT)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
        .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
        .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .gnt_o(gnt_o)
    );

    always #5 clk_i = ~clk_i;

    logic        drv_stb [2];
    logic        drv_we  [2];
    logic [29:0] drv_adr [2];
    logic [3:0]  drv_sel [2];
    logic [31:0] drv_dat [2];
    assign m0_stb_i = drv_stb[0];  assign m1_stb_i = drv_stb[1];
    assign m0_we_i  = drv_we[0];   assign m1_we_i  = drv_we[1];
    assign m0_adr_i = drv_adr[0];  assign m1_adr_i = drv_adr[1];
    assign m0_sel_i = drv_sel[0];  assign m1_sel_i = drv_sel[1];
    assign m0_dat_i = drv_dat[0];  assign m1_dat_i = drv_dat[1];

    logic [1:0]  mo_ack, mo_err;
    logic [31:0] mo_dat [2];
    assign mo_ack    = {m1_ack_o, m0_ack_o};
    assign mo_err    = {m1_err_o, m0_err_o};
    assign mo_dat[0] = m0_dat_o;
    assign mo_dat[1] = m1_dat_o;

    txn_t mq0[$], mq1[$], st0[$], st1[$], plan[$];
    exp_t expq[$];
    txn_t cur [2];
    bit   active [2];
    bit   done [2];
    int   gcount [2];
    int   req_cyc [2];
    int   sidx;
    int   cyc = 0;
    int   model_last;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic [29:0] adr, input logic [3:0] sel,
                                input logic [31:0] dat, input int l, input logic [31:0] rd,
                                input int ab, input int lat);
        txn_t t;
        t.we = we; t.adr = adr; t.sel = sel; t.dat = dat;
        t.lat_l = l; t.rdata = rd; t.abort_k = ab; t.lat_exp = lat;
        return t;
    endfunction

    function automatic txn_t rnd_txn();
        txn_t t;
        int   r;
        r = int'($urandom_range(0, 9));
        t = mk(1'($urandom), 30'($urandom), 4'($urandom), $urandom,
               (r < 7) ? (r % 5) : NEVER, $urandom, 0, -1);
        if ($urandom_range(0, 5) == 0) begin
            t.abort_k = int'($urandom_range(2, 3));
            t.lat_l   = NEVER;
        end
        return t;
    endfunction

    // Reference model: both masters start together and re-request immediately,
    // so grants alternate away from the last owner while both have work left.
    task automatic launch();
        int   p0 = 0;
        int   p1 = 0;
        int   pick;
        txn_t t;
        exp_t e;
        while (p0 < st0.size() || p1 < st1.size()) begin
            if (p0 < st0.size() && p1 < st1.size()) pick = (model_last == 1) ? 0 : 1;
            else                                     pick = (p0 < st0.size()) ? 0 : 1;
            if (pick == 1) begin t = st1[p1]; p1++; end
            else           begin t = st0[p0]; p0++; end
            plan.push_back(t);
            if (t.abort_k == 0) begin
                e.mid    = pick;
                e.is_err = (t.lat_l >= TMO);
                e.dat    = e.is_err ? EDAT : t.rdata;
                e.lat    = t.lat_exp;
                expq.push_back(e);
            end
            model_last = pick;
        end
        foreach (st0[i]) mq0.push_back(st0[i]);
        foreach (st1[i]) mq1.push_back(st1[i]);
        st0.delete();
        st1.delete();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            if (mq0.size() == 0 && mq1.size() == 0 && plan.size() == 0 && expq.size() == 0 &&
                !active[0] && !active[1] && gnt_o == 2'b00) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL wait_idle: bus still busy after 3000 cycles, exp=%0d plan=%0d",
                 expq.size(), plan.size());
    endtask

    // Master drivers and reactive slave
    initial begin
        bit jd;
        for (int m = 0; m < 2; m++) begin
            drv_stb[m] = 0; drv_we[m] = 0; drv_adr[m] = '0; drv_sel[m] = '0; drv_dat[m] = '0;
            active[m] = 0; done[m] = 0; gcount[m] = 0; req_cyc[m] = 0;
        end
        s_ack_i = 0;
        s_dat_i = '0;
        sidx    = 0;
        forever begin
            @(negedge clk_i);
            done[0] = m0_ack_o | m0_err_o;
            done[1] = m1_ack_o | m1_err_o;
            @(posedge clk_i);
            #1;
            if (!rst_i) begin
                for (int m = 0; m < 2; m++) begin
                    active[m] = 0; done[m] = 0; drv_stb[m] = 0;
                end
                if (sidx > 0 && plan.size() > 0) void'(plan.pop_front());
                sidx = 0; s_ack_i = 0; s_dat_i = '0;
                continue;
            end
            for (int m = 0; m < 2; m++) begin
                jd = 0;
                if (active[m]) begin
                    if (done[m]) active[m] = 0;
                    else if (cur[m].abort_k > 0) begin
                        if (gnt_o[m]) gcount[m]++;
                        if (gcount[m] == cur[m].abort_k) begin active[m] = 0; jd = 1; end
                    end
                end
                if (!active[m] && !jd && ((m == 0) ? mq0.size() : mq1.size()) > 0) begin
                    cur[m]     = (m == 0) ? mq0.pop_front() : mq1.pop_front();
                    active[m]  = 1;
                    gcount[m]  = 0;
                    req_cyc[m] = cyc;
                end
                drv_stb[m] = active[m];
                drv_we[m]  = cur[m].we;
                drv_adr[m] = cur[m].adr;
                drv_sel[m] = cur[m].sel;
                drv_dat[m] = cur[m].dat;
                done[m]    = 0;
            end
            // Raise ack tentatively so s_stb_o shows whether a cycle is really active.
            s_ack_i = 1;
            #1;
            if (s_stb_o && plan.size() > 0) begin
                s_ack_i = (sidx == plan[0].lat_l);
                s_dat_i = plan[0].rdata;
                sidx++;
            end else begin
                if (sidx > 0 && !s_stb_o && plan.size() > 0) void'(plan.pop_front());
                sidx = 0; s_ack_i = 0; s_dat_i = '0;
            end
        end
    end

    // Monitor: per-cycle rules plus scoreboard pops on every ack/err
    initial begin
        bit   exp_idle = 0;
        int   g;
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin exp_idle = 0; continue; end
            chk("gnt_not_11", 32'(gnt_o == 2'b11), 0);
            for (int m = 0; m < 2; m++) begin
                chk("ack_err_excl", 32'(mo_ack[m] & mo_err[m]), 0);
                if (!gnt_o[m])
                    chk($sformatf("m%0d_ungranted_quiet", m),
                        32'(mo_ack[m] | mo_err[m] | (mo_dat[m] != 0)), 0);
            end
            if (s_stb_o) begin
                g = gnt_o[1] ? 1 : 0;
                chk("stb_has_gnt", 32'(gnt_o != 2'b00), 1);
                chk("s_adr", 32'(s_adr_o), 32'(drv_adr[g]));
                chk("s_we",  32'(s_we_o),  32'(drv_we[g]));
                chk("s_sel", 32'(s_sel_o), 32'(drv_sel[g]));
                chk("s_dat", s_dat_o, drv_dat[g]);
            end
            if (exp_idle) begin
                chk("idle_after_term", {30'd0, gnt_o} | 32'(s_stb_o), 0);
                exp_idle = 0;
            end
            for (int m = 0; m < 2; m++) begin
                if (mo_ack[m] | mo_err[m]) begin
                    exp_idle = 1;
                    if (expq.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_resp: m%0d ack=%0b err=%0b, expected none",
                                 m, mo_ack[m], mo_err[m]);
                    end else begin
                        e = expq.pop_front();
                        chk("resp_master", m, e.mid);
                        chk("resp_is_err", 32'(mo_err[m]), 32'(e.is_err));
                        chk("resp_dat", mo_dat[m], e.dat);
                        chk("resp_gnt", 32'(gnt_o), (m == 0) ? 1 : 2);
                        if (mo_err[m]) chk("err_stb_low", 32'(s_stb_o), 0);
                        if (e.lat >= 0) chk("resp_latency", cyc - req_cyc[m], e.lat);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        bit got;
        model_last = 1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_s_stb", 32'(s_stb_o), 0);
        chk("rst_gnt", 32'(gnt_o), 0);
        chk("rst_m_resp", {28'd0, mo_ack, mo_err}, 0);
        chk("rst_m_dat", m0_dat_o | m1_dat_o | s_dat_o, 0);
        chk("rst_s_ctl", {s_adr_o, s_sel_o} != 0, 0);
        rst_i = 1;

        // single m0 read
        st0.push_back(mk(0, 30'h4, 4'hF, 32'h0, 2, 32'h12345678, 0, 3));
        launch();
        wait_idle();

        // contention, slave acks one cycle after stb rises
        for (int i = 0; i < 2; i++) begin
            st0.push_back(mk(0, 30'($urandom), 4'hF, $urandom, 1, $urandom, 0, -1));
            st1.push_back(mk(0, 30'($urandom), 4'hF, $urandom, 1, $urandom, 0, -1));
        end
        launch();
        wait_idle();

        // watchdog, then ack on the last allowed cycle
        st0.push_back(mk(0, 30'h10, 4'hF, 32'h0, NEVER, 32'h0, 0, TMO));
        launch();
        wait_idle();
        st0.push_back(mk(0, 30'h11, 4'hF, 32'h0, TMO - 1, 32'hCAFE0001, 0, TMO));
        launch();
        wait_idle();

        // m1 write
        st1.push_back(mk(1, 30'h2A, 4'b0011, 32'hA5A5A5A5, 1, 32'h0, 0, 2));
        launch();
        wait_idle();

        // m0 aborts in its second BUSY cycle while m1 waits
        st0.push_back(mk(0, 30'h20, 4'hF, 32'h0, NEVER, 32'h0, 2, -1));
        st1.push_back(mk(0, 30'h21, 4'hF, 32'h0, 1, 32'h55AA55AA, 0, 5));
        launch();
        wait_idle();

        for (int r = 0; r < 25; r++) begin
            int n0 = int'($urandom_range(0, 3));
            int n1 = int'($urandom_range(0, 3));
            for (int i = 0; i < n0; i++) st0.push_back(rnd_txn());
            for (int i = 0; i < n1; i++) st1.push_back(rnd_txn());
            launch();
            wait_idle();
        end

        // reset in the middle of a BUSY cycle
        mq0.push_back(mk(0, 30'h30, 4'hF, 32'h0, NEVER, 32'h0, 0, -1));
        plan.push_back(mk(0, 30'h30, 4'hF, 32'h0, NEVER, 32'h0, 0, -1));
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk_i);
            if (gnt_o == 2'b01) got = 1;
        end
        chk("rst_test_granted", 32'(got), 1);
        #1 rst_i = 0;
        #1;
        chk("async_rst_stb", 32'(s_stb_o), 0);
        chk("async_rst_gnt", 32'(gnt_o), 0);
        chk("async_rst_resp", {30'd0, m0_ack_o, m0_err_o}, 0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1;
        model_last = 1;
        st0.push_back(mk(0, 30'h31, 4'hF, 32'h0, 1, 32'h0BADF00D, 0, 2));
        st1.push_back(mk(0, 30'h32, 4'hF, 32'h0, 1, 32'h600DF00D, 0, 5));
        launch();
        wait_idle();

        repeat (3) @(negedge clk_i);
        chk("scoreboard_drained", expq.size() + plan.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
